// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, shared-ALU and response signals of alu_arbiter.
// The slave modport is the arbiter itself. The master modport is the environment around it.
interface alu_arbiter_if;
  logic        req0_valid_i;
  logic        req1_valid_i;
  logic        req0_ready_o;
  logic        req1_ready_o;
  logic [31:0] req0_src1_i;
  logic [31:0] req0_src2_i;
  logic [3:0]  req0_ctrl_i;
  logic [4:0]  req0_shamt_i;
  logic [31:0] req1_src1_i;
  logic [31:0] req1_src2_i;
  logic [3:0]  req1_ctrl_i;
  logic [4:0]  req1_shamt_i;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  alu_shamt_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o;
  logic        rsp_id_o;
  logic        rsp_ready_i;
  logic        busy_o;

  modport slave (
    input  req0_valid_i, req1_valid_i,
    input  req0_src1_i, req0_src2_i, req0_ctrl_i, req0_shamt_i,
    input  req1_src1_i, req1_src2_i, req1_ctrl_i, req1_shamt_i,
    input  alu_result_i, alu_zero_i, rsp_ready_i,
    output req0_ready_o, req1_ready_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o,
    output rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_id_o, busy_o
  );

  modport master (
    output req0_valid_i, req1_valid_i,
    output req0_src1_i, req0_src2_i, req0_ctrl_i, req0_shamt_i,
    output req1_src1_i, req1_src2_i, req1_ctrl_i, req1_shamt_i,
    output alu_result_i, alu_zero_i, rsp_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o,
    input  rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_id_o, busy_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each operation is accepted, then executed, then held as a response until it is consumed.
module alu_arbiter (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic        r_id;
  logic        w_accept;
  logic        w_grant;
  logic [31:0] r_alu_src1;
  logic [31:0] r_alu_src2;
  logic [3:0]  r_alu_ctrl;
  logic [4:0]  r_alu_shamt;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic        r_rsp_zero;
  logic        r_rsp_id;

  // Next-state and grant decision; the accept signal is gated by reset so ready never rises while reset is active
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_grant      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_i && (bus.req0_valid_i || bus.req1_valid_i)) begin
          w_accept     = 1'b1;
          w_next_state = EXEC;
          if (bus.req0_valid_i && bus.req1_valid_i) begin
            w_grant = ~r_last_grant;
          end else begin
            w_grant = bus.req1_valid_i;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      EXEC: begin
        w_next_state = RESP;
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, operand, grant and response registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_alu_src1   <= 32'd0;
      r_alu_src2   <= 32'd0;
      r_alu_ctrl   <= 4'd0;
      r_alu_shamt  <= 5'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 32'd0;
      r_rsp_zero   <= 1'b0;
      r_rsp_id     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_id         <= w_grant;
        r_alu_src1   <= w_grant ? bus.req1_src1_i  : bus.req0_src1_i;
        r_alu_src2   <= w_grant ? bus.req1_src2_i  : bus.req0_src2_i;
        r_alu_ctrl   <= w_grant ? bus.req1_ctrl_i  : bus.req0_ctrl_i;
        r_alu_shamt  <= w_grant ? bus.req1_shamt_i : bus.req0_shamt_i;
      end
      if (r_state == EXEC) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= bus.alu_result_i;
        r_rsp_zero   <= bus.alu_zero_i;
        r_rsp_id     <= r_id;
      end else if (r_state == RESP && bus.rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req0_ready_o = w_accept & ~w_grant;
  assign bus.req1_ready_o = w_accept &  w_grant;
  assign bus.alu_src1_o   = r_alu_src1;
  assign bus.alu_src2_o   = r_alu_src2;
  assign bus.alu_ctrl_o   = r_alu_ctrl;
  assign bus.alu_shamt_o  = r_alu_shamt;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_result_o = r_rsp_result;
  assign bus.rsp_zero_o   = r_rsp_zero;
  assign bus.rsp_id_o     = r_rsp_id;
  assign bus.busy_o       = (r_state != IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: synchronous, active-low reset; sampled only on rising clk_i.
REQ-003 SHALL have ports req0_valid_i / req1_valid_i, input, 1 bit each: requester N presents an operation.
REQ-004 SHALL have ports req0_ready_o / req1_ready_o, output, 1 bit each: operation from requester N accepted this cycle.
REQ-005 SHALL have ports reqN_src1_i, reqN_src2_i (32 bits), reqN_ctrl_i (4 bits) and reqN_shamt_i (5 bits), input: operands, ALU control code and shift amount of requester N.
REQ-006 SHALL have ports alu_src1_o, alu_src2_o (32 bits), alu_ctrl_o (4 bits) and alu_shamt_o (5 bits), output: registered operands driving the shared ALU.
REQ-007 SHALL have ports alu_result_i (32 bits) and alu_zero_i (1 bit), input: combinational ALU outputs.
REQ-008 SHALL have ports rsp_valid_o (1 bit), rsp_result_o (32 bits), rsp_zero_o (1 bit) and rsp_id_o (1 bit), output: response, captured result, zero flag and index of the owning requester.
REQ-009 SHALL have port rsp_ready_i, input, 1 bit: consumer accepts the response.
REQ-010 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-012 In IDLE, SHALL accept exactly one request when any reqN_valid_i is high: the accepted requester's ready is 1 for that cycle only and the other ready is 0.
REQ-013 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it; last_grant updates only on accept.
REQ-014 On accept, SHALL register the granted src1/src2/ctrl/shamt into alu_*_o and the grant index into an id register, and go to EXEC.
REQ-015 In EXEC (exactly one cycle), SHALL capture alu_result_i and alu_zero_i into rsp_result_o/rsp_zero_o, set rsp_valid_o=1 on the next edge, and go to RESP.
REQ-016 In RESP, SHALL hold rsp_valid_o, rsp_result_o, rsp_zero_o and rsp_id_o stable until rsp_ready_i=1 is sampled, then clear rsp_valid_o and go to IDLE.
REQ-017 reqN_ready_o SHALL be 0 in EXEC and RESP regardless of valids; a new accept is possible no earlier than the cycle after the RESP handshake.
REQ-018 Latency SHALL be fixed: accept at edge k gives rsp_valid_o=1 after edge k+2; minimum issue interval is 3 cycles.
REQ-019 alu_*_o SHALL hold the last accepted operation and be unchanged in EXEC, RESP and IDLE until the next accept.
REQ-020 Operands and ctrl SHALL pass through unmodified: no width extension, sign handling or ctrl decoding in this block.
REQ-021 rsp_ready_i SHALL be ignored when rsp_valid_o=0.
REQ-022 A requester whose valid drops before grant SHALL simply not be granted; no request is queued.

Reset
REQ-023 When rst_i=0 at a rising edge: state<=IDLE; rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_id_o<=0; alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o<=0; last_grant<=1, so requester 0 wins the first tie.
REQ-024 Reset asserted in EXEC or RESP SHALL abandon the in-flight operation; no response is ever issued for it.
REQ-025 reqN_ready_o SHALL be 0 in any cycle where rst_i=0.

Verification
REQ-026 Sequence: reset, then req0 valid, src1=5, src2=3, ctrl=0001 -> req0_ready_o=1 for one cycle; two edges later rsp_valid_o=1, rsp_result_o=8, rsp_id_o=0.
REQ-027 Sequence: both requesters held valid with rsp_ready_i=1 for 4 operations -> grants go 0,1,0,1 and rsp_id_o follows the same order.
REQ-028 Sequence: req1 ctrl=1000, src1=src2=7, rsp_ready_i=0 for 5 cycles -> rsp_valid_o, rsp_zero_o=1 and rsp_id_o=1 are stable for all 5 cycles; both readies stay 0; IDLE on the cycle after rsp_ready_i=1.
REQ-029 Sequence: req0 ctrl=0010, src1=0, src2=1 -> rsp_result_o=32'hFFFFFFFF.
REQ-030 Sequence: rst_i=0 during EXEC -> the next cycle shows busy_o=0, rsp_valid_o=0 and all alu_*_o=0; no response appears afterwards.
